// File: rtl/instruction_mem.sv
// instruction_mem: word-organised RV32 fetch memory with default image restored on reset; INSTRUCTION_MEM_LOAD_EN adds a program-load write port
module instruction_mem #(
  parameter int DEPTH = 256,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef INSTRUCTION_MEM_LOAD_EN
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
`endif
  input  logic [31:0] read_addr,
  output logic [31:0] instruction,
  output logic        misaligned,
  output logic        out_of_range
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(DEPTH) << 2;
  localparam logic [31:0] IMAGE [DEPTH] = '{
    0: 32'h0050_0093, 1: 32'h00A0_0113, 2: 32'h0020_81B3, 3: 32'h4011_0233,
    4: 32'h0020_F2B3, 5: 32'h0020_E333, 6: 32'h0030_2023, 7: 32'h0000_2383,
    default: NOP_WORD
  };
  logic [31:0] mem [DEPTH] = IMAGE;
  always_ff @(posedge clk) begin
    if (!rst_n) mem <= IMAGE;
`ifdef INSTRUCTION_MEM_LOAD_EN
    else if (load_en && load_addr < LIMIT) mem[load_addr[AW+1:2]] <= load_data;
`endif
  end
  always_comb begin
    out_of_range = read_addr >= LIMIT;
    misaligned = read_addr[1:0] != 2'b00;
    instruction = out_of_range ? NOP_WORD : mem[read_addr[AW+1:2]];
  end
endmodule

// File: tb/tb_instruction_mem.sv
// tb_instruction_mem: randomized scoreboard bench for instruction_mem against a word-array reference model
module tb_instruction_mem;
  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {
    logic [31:0] a;
    logic [31:0] ins;
    logic        mis;
    logic        oor;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic [31:0] read_addr = '0;
  logic [31:0] instruction;
  logic misaligned, out_of_range;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  logic [31:0] model [DEPTH];
  logic [31:0] boot [8] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40110233,
                            32'h0020F2B3, 32'h0020E333, 32'h00302023, 32'h00002383};

  instruction_mem #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef INSTRUCTION_MEM_LOAD_EN
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
`endif
    .read_addr(read_addr),
    .instruction(instruction),
    .misaligned(misaligned),
    .out_of_range(out_of_range)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = (i < 8) ? boot[i] : NOP;
  endfunction

  // One clock cycle: drive inputs, predict the pre-edge read, then apply the edge to the model.
  task automatic step(input logic [31:0] a, input logic r = 1'b1, input logic le = 1'b0,
                      input logic [31:0] la = '0, input logic [31:0] ld = '0);
    exp_t e;
    read_addr = a;
    rst_n = r;
    load_en = le;
    load_addr = la;
    load_data = ld;
    e.a = a;
    e.oor = a >= DEPTH * 4;
    e.mis = (a % 4) != 0;
    e.ins = e.oor ? NOP : model[a / 4];
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!r) model_reset();
`ifdef INSTRUCTION_MEM_LOAD_EN
    else if (le && la < DEPTH * 4) model[la / 4] = ld;
`endif
    rst_n = 1'b1;
    load_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total += 3;
      if (instruction !== e.ins) begin
        bad++;
        $display("FAIL instruction addr=%h got=%h want=%h", e.a, instruction, e.ins);
      end
      if (misaligned !== e.mis) begin
        bad++;
        $display("FAIL misaligned addr=%h got=%b want=%b", e.a, misaligned, e.mis);
      end
      if (out_of_range !== e.oor) begin
        bad++;
        $display("FAIL out_of_range addr=%h got=%b want=%b", e.a, out_of_range, e.oor);
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) step(32'(i * 4));
    step(32'd2);
    step(32'd31);
    step(32'd1000);
    step(32'd1020);
    step(32'd1024);
    step(32'hFFFF_FFFC);
    step(32'd0, 1'b0);
    step(32'd8);
`ifdef INSTRUCTION_MEM_LOAD_EN
    step(32'd8, 1'b1, 1'b1, 32'd8, 32'hDEAD_BEEF);
    step(32'd8);
    step(32'd8, 1'b0);
    step(32'd8);
    step(32'd0, 1'b0, 1'b1, 32'd0, 32'h1234_5678);
    step(32'd0);
    step(32'd0, 1'b1, 1'b1, 32'd1026, 32'hCAFE_F00D);
    step(32'd0, 1'b1, 1'b1, 32'd1024, 32'hCAFE_F00D);
    step(32'd0);
    step(32'd4, 1'b1, 1'b1, 32'd1023, 32'hA5A5_5A5A);
    step(32'd1020);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, la;
      a = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, DEPTH * 4 + 15);
      la = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, DEPTH * 4 - 1);
      step(a, $urandom_range(0, 29) != 0, $urandom_range(0, 1) == 1, la, $urandom);
    end
`endif
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, DEPTH * 4 + 15);
      step(a, $urandom_range(0, 19) != 0);
    end
    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_mem.md
# instruction_mem

Word-organised RV32 instruction memory for the single-cycle core's fetch stage. Returns the 32-bit instruction at a byte address with zero-cycle combinational read latency. Holds a built-in default program image, which is restored on reset. Optionally accepts a synchronous program-load write port.

## Interface
- DEPTH, 256: number of 32-bit words (1 KiB); must be a power of two, ≥ 8.
- NOP_WORD, 32'h0000_0013: value returned for out-of-range reads and stored in unused words (`addi x0,x0,0`).
- clk  in  1  rising-edge clock; used only for reset and load writes.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- read_addr  in  32  byte address from the PC.
- instruction  out  32  fetched instruction word.
- misaligned  out  1  high when read_addr[1:0] != 0.
- out_of_range  out  1  high when read_addr >= DEPTH*4.
- load_en  in  1  write strobe (only with INSTRUCTION_MEM_LOAD_EN).
- load_addr  in  32  byte address of the load write (only with the macro).
- load_data  in  32  word to write (only with the macro).

## Operation
- Word index = read_addr[log2(DEPTH)+1:2]; read_addr[1:0] is ignored for data selection.
  - A misaligned read returns the containing word and asserts misaligned.
- If read_addr >= DEPTH*4: instruction = NOP_WORD and out_of_range = 1; the array is not indexed.
- Default image, words 0..7, at byte addresses 0,4,…,28:
  - 0x00500093, 0x00A00113, 0x002081B3, 0x40110233
  - 0x0020F2B3, 0x0020E333, 0x00302023, 0x00002383
  - This is addi x1,5; addi x2,10; add x3; sub x4; and x5; or x6; sw x3,0(x0); lw x7,0(x0).
  - Words 8..DEPTH-1 = NOP_WORD.
- Array initialised to the default image at time zero, so fetch is valid before the first reset edge.
- Reset (rst_n low at a rising clk) rewrites every word with the default image.
  - All writes in a reset cycle complete in that single edge; no multi-cycle init sequence.
- Load write, when compiled in:
  - Condition: rising clk with rst_n high and load_en high.
  - Action: writes load_data to word load_addr[log2(DEPTH)+1:2].
  - load_addr[1:0] is ignored.
  - A load_addr >= DEPTH*4 is dropped silently.
- Simultaneous reset and load_en: reset wins and the load is discarded.
- No read side effects; the read path holds no state.

## Timing
- instruction, misaligned, out_of_range are purely combinational from read_addr and array contents; latency 0 cycles.
- Writes (reset or load) take effect at the rising clk edge.
  - A read of the same word in the cycle before the edge returns old data; after the edge it returns new data.
- Output values after reset, for any read_addr:
  - instruction = default image word (or NOP_WORD if out of range).
  - misaligned and out_of_range are determined by read_addr alone.
- Reset asserted mid-program-load restores the full default image at that edge; earlier loads are lost.

## Configuration
- INSTRUCTION_MEM_LOAD_EN defined:
  - load_en, load_addr and load_data ports exist.
  - The write path is as described under Operation.
- Not defined:
  - Those three ports are absent.
  - The memory is read-only apart from the reset restore of the default image.

## Test plan
- Sequential fetch: read_addr 0,4,…,28 at 10 ns intervals -> instruction 0x00500093, 0x00A00113, 0x002081B3, 0x40110233, 0x0020F2B3, 0x0020E333, 0x00302023, 0x00002383; both flags 0.
- Misaligned: read_addr=2 -> instruction=0x00500093, misaligned=1, out_of_range=0; read_addr=31 -> 0x00002383, misaligned=1.
- Far in-range address: read_addr=1000 (word 250) -> instruction=0x00000013, both flags 0.
- Out of range: read_addr=1024 and 0xFFFF_FFFC -> instruction=0x00000013, out_of_range=1.
- Load then reset (macro on):
  - Write 0xDEADBEEF to load_addr=8 -> read_addr=8 returns 0xDEADBEEF after the edge and 0x002081B3 before it.
  - One clk with rst_n=0 -> read_addr=8 returns 0x002081B3.
- Reset/load collision (macro on): rst_n=0 and load_en=1, load_addr=0, load_data=0x12345678 on the same edge -> read_addr=0 returns 0x00500093.
